// File: rtl/cpu6_pipe_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage CPU: load-use bubbles, branch flushes,
// exception flushes, memory-wait freeze and a fixed-latency multi-cycle mul/div sequencer.
module cpu6_pipe_ctrl #(
   parameter int unsigned MD_LAT = 8,
   parameter int unsigned SCW    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ext_stall,
   input  logic           exc,
   input  logic           br_taken,
   input  logic           ex_load,
   input  logic [4:0]     ex_rd,
   input  logic [4:0]     id_rs1,
   input  logic [4:0]     id_rs2,
   input  logic           id_rs1_used,
   input  logic           id_rs2_used,
   input  logic           md_start,
   output logic           if_lden,
   output logic           id_lden,
   output logic           ex_lden,
   output logic           mem_lden,
   output logic           wb_lden,
   output logic           id_flush,
   output logic           ex_flush,
   output logic           mem_flush,
   output logic           md_busy,
   output logic           md_done,
   output logic [SCW-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, MDWAIT, MDHOLD} state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

   state_t         r_state;
   logic [3:0]     r_md_cnt;
   logic           r_md_busy;
   logic [SCW-1:0] r_stall_cnt;

   logic w_load_use;
   logic w_md_active;
   logic w_md_exit;

   // x0 is hardwired zero, so a load targeting it never hazards
   assign w_load_use = ex_load && (ex_rd != 5'd0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

   assign w_md_active = (r_state != RUN);
   assign w_md_exit   = !exc && !ext_stall &&
                        (((r_state == MDWAIT) && (r_md_cnt == 4'd0)) || (r_state == MDHOLD));

   always_comb begin
      if_lden   = 1'b1;
      id_lden   = 1'b1;
      ex_lden   = 1'b1;
      mem_lden  = 1'b1;
      wb_lden   = 1'b1;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
      md_done   = 1'b0;
      if (!rst_n) begin
         {if_lden, id_lden, ex_lden, mem_lden, wb_lden} = '0;
      end else if (exc) begin
         {id_flush, ex_flush, mem_flush} = '1;
      end else if (ext_stall) begin
         {if_lden, id_lden, ex_lden, mem_lden, wb_lden} = '0;
      end else if (w_md_active) begin
         if (w_md_exit) begin
            md_done = 1'b1;
         end else begin
            {if_lden, id_lden, ex_lden} = '0;
            mem_flush = 1'b1;
         end
      end else if (md_start) begin
         {if_lden, id_lden, ex_lden} = '0;
         mem_flush = 1'b1;
      end else if (br_taken) begin
         id_flush = 1'b1;
         ex_flush = 1'b1;
      end else if (w_load_use) begin
         if_lden  = 1'b0;
         id_lden  = 1'b0;
         ex_flush = 1'b1;
      end
   end

   // md_cnt keeps counting under ext_stall; reaching zero while frozen parks in MDHOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_md_cnt    <= 4'd0;
         r_md_busy   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (!if_lden && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + SCW'(1);
         if (exc) begin
            r_state   <= RUN;
            r_md_cnt  <= 4'd0;
            r_md_busy <= 1'b0;
         end else begin
            unique case (r_state)
               RUN: begin
                  if (!ext_stall && md_start) begin
                     r_state   <= MDWAIT;
                     r_md_cnt  <= MD_INIT;
                     r_md_busy <= 1'b1;
                  end
               end
               MDWAIT: begin
                  if (r_md_cnt == 4'd0) begin
                     if (ext_stall) begin
                        r_state <= MDHOLD;
                     end else begin
                        r_state   <= RUN;
                        r_md_busy <= 1'b0;
                     end
                  end else begin
                     r_md_cnt <= r_md_cnt - 4'd1;
                  end
               end
               MDHOLD: begin
                  if (!ext_stall) begin
                     r_state   <= RUN;
                     r_md_busy <= 1'b0;
                  end
               end
               default: begin
                  r_state   <= RUN;
                  r_md_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign md_busy   = r_md_busy;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_cpu6_pipe_ctrl.sv
// Directed self-checking bench for cpu6_pipe_ctrl; a second instance with SCW=4
// shares the stimulus and is used for the saturation scenario.
module tb_cpu6_pipe_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic ext_stall, exc, br_taken, ex_load, md_start;
   logic [4:0] ex_rd, id_rs1, id_rs2;
   logic id_rs1_used, id_rs2_used;

   logic if_lden, id_lden, ex_lden, mem_lden, wb_lden;
   logic id_flush, ex_flush, mem_flush, md_busy, md_done;
   logic [15:0] stall_cnt;

   logic s_if_lden, s_id_lden, s_ex_lden, s_mem_lden, s_wb_lden;
   logic s_id_flush, s_ex_flush, s_mem_flush, s_md_busy, s_md_done;
   logic [3:0] s_stall_cnt;

   logic [4:0] lden;
   logic [2:0] flush;
   assign lden  = {if_lden, id_lden, ex_lden, mem_lden, wb_lden};
   assign flush = {id_flush, ex_flush, mem_flush};

   int checks = 0;
   int failures = 0;
   int unsigned exp_stall = 0;

   always #5 clk = ~clk;

   cpu6_pipe_ctrl #(.MD_LAT(8), .SCW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .exc(exc), .br_taken(br_taken),
      .ex_load(ex_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .md_start(md_start),
      .if_lden(if_lden), .id_lden(id_lden), .ex_lden(ex_lden), .mem_lden(mem_lden),
      .wb_lden(wb_lden), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
   );

   cpu6_pipe_ctrl #(.MD_LAT(8), .SCW(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .exc(exc), .br_taken(br_taken),
      .ex_load(ex_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .md_start(md_start),
      .if_lden(s_if_lden), .id_lden(s_id_lden), .ex_lden(s_ex_lden), .mem_lden(s_mem_lden),
      .wb_lden(s_wb_lden), .id_flush(s_id_flush), .ex_flush(s_ex_flush), .mem_flush(s_mem_flush),
      .md_busy(s_md_busy), .md_done(s_md_done), .stall_cnt(s_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ext_stall = 0; exc = 0; br_taken = 0; ex_load = 0; md_start = 0;
      ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      #1 rst_n = 0;
      #1;
      checks++; if (lden !== 5'b00000) begin failures++; $display("FAIL reset_lden: got %b expected %b", lden, 5'b00000); end
      checks++; if (flush !== 3'b000) begin failures++; $display("FAIL reset_flush: got %b expected %b", flush, 3'b000); end
      checks++; if ({md_busy, md_done} !== 2'b00) begin failures++; $display("FAIL reset_md: got %b expected %b", {md_busy, md_done}, 2'b00); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
      repeat (2) @(posedge clk);
      #4 rst_n = 1;
      tick();
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL run_lden: got %b expected %b", lden, 5'b11111); end
      checks++; if (flush !== 3'b000) begin failures++; $display("FAIL run_flush: got %b expected %b", flush, 3'b000); end
   endtask

   task automatic test_load_use();
      ex_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
      #1;
      checks++; if (lden !== 5'b00111) begin failures++; $display("FAIL lu_lden: got %b expected %b", lden, 5'b00111); end
      checks++; if (flush !== 3'b010) begin failures++; $display("FAIL lu_flush: got %b expected %b", flush, 3'b010); end
      tick(); clear_inputs(); exp_stall += 1;
      #1;
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL lu_after: got %b expected %b", lden, 5'b11111); end
      ex_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
      #1;
      checks++; if (lden !== 5'b00111) begin failures++; $display("FAIL lu_rs2: got %b expected %b", lden, 5'b00111); end
      id_rs2_used = 0;
      #1;
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL lu_rs2_unused: got %b expected %b", lden, 5'b11111); end
      ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
      #1;
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL lu_x0: got %b expected %b", lden, 5'b11111); end
      clear_inputs();
      tick();
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL lu_stall: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_branch();
      br_taken = 1; ex_load = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
      #1;
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL br_lden: got %b expected %b", lden, 5'b11111); end
      checks++; if (flush !== 3'b110) begin failures++; $display("FAIL br_flush: got %b expected %b", flush, 3'b110); end
      tick(); clear_inputs();
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL br_stall: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_muldiv();
      md_start = 1;
      #1;
      checks++; if (lden !== 5'b00011) begin failures++; $display("FAIL md_start_lden: got %b expected %b", lden, 5'b00011); end
      checks++; if (flush !== 3'b001) begin failures++; $display("FAIL md_start_flush: got %b expected %b", flush, 3'b001); end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL md_start_busy: got %b expected 0", md_busy); end
      tick(); clear_inputs();
      for (int k = 1; k <= 9; k++) begin
         if (k == 3) begin md_start = 1; br_taken = 1; end
         #1;
         checks++; if (md_busy !== (k <= 8)) begin failures++; $display("FAIL md_busy c%0d: got %b expected %b", k, md_busy, (k <= 8)); end
         checks++; if (md_done !== (k == 8)) begin failures++; $display("FAIL md_done c%0d: got %b expected %b", k, md_done, (k == 8)); end
         checks++; if (lden !== ((k < 8) ? 5'b00011 : 5'b11111)) begin failures++; $display("FAIL md_lden c%0d: got %b", k, lden); end
         checks++; if (flush !== ((k < 8) ? 3'b001 : 3'b000)) begin failures++; $display("FAIL md_flush c%0d: got %b", k, flush); end
         tick(); clear_inputs();
      end
      exp_stall += 8;
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL md_stall: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_stall_overlap();
      logic st;
      md_start = 1;
      tick(); clear_inputs();
      for (int k = 1; k <= 12; k++) begin
         st = (k == 2) || (k == 3) || ((k >= 6) && (k <= 10));
         ext_stall = st;
         #1;
         checks++; if (md_busy !== (k <= 11)) begin failures++; $display("FAIL ov_busy c%0d: got %b expected %b", k, md_busy, (k <= 11)); end
         checks++; if (md_done !== (k == 11)) begin failures++; $display("FAIL ov_done c%0d: got %b expected %b", k, md_done, (k == 11)); end
         checks++; if (lden !== (st ? 5'b00000 : ((k <= 10) ? 5'b00011 : 5'b11111))) begin failures++; $display("FAIL ov_lden c%0d: got %b", k, lden); end
         checks++; if (flush !== ((st || k > 10) ? 3'b000 : 3'b001)) begin failures++; $display("FAIL ov_flush c%0d: got %b", k, flush); end
         tick(); clear_inputs();
      end
      exp_stall += 11;
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL ov_stall: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_exception();
      md_start = 1;
      tick(); clear_inputs();
      repeat (4) tick();
      exc = 1;
      #1;
      checks++; if (lden !== 5'b11111) begin failures++; $display("FAIL exc_lden: got %b expected %b", lden, 5'b11111); end
      checks++; if (flush !== 3'b111) begin failures++; $display("FAIL exc_flush: got %b expected %b", flush, 3'b111); end
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL exc_done: got %b expected 0", md_done); end
      tick(); clear_inputs();
      exp_stall += 5;
      for (int k = 0; k < 10; k++) begin
         #1;
         checks++; if ({md_busy, md_done, lden} !== 7'b0011111) begin failures++; $display("FAIL exc_after c%0d: got %b expected %b", k, {md_busy, md_done, lden}, 7'b0011111); end
         tick();
      end
      exc = 1; ext_stall = 1;
      #1;
      checks++; if ({lden, flush} !== 8'b11111111) begin failures++; $display("FAIL exc_prio: got %b expected %b", {lden, flush}, 8'b11111111); end
      exc = 0;
      #1;
      checks++; if ({lden, flush} !== 8'b00000000) begin failures++; $display("FAIL ext_stall: got %b expected %b", {lden, flush}, 8'b00000000); end
      clear_inputs();
      tick();
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL exc_stall: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_reset_mid();
      md_start = 1;
      tick(); clear_inputs();
      repeat (2) tick();
      #1 rst_n = 0;
      #1;
      checks++; if ({lden, flush} !== 8'b00000000) begin failures++; $display("FAIL rmid_out: got %b expected %b", {lden, flush}, 8'b00000000); end
      checks++; if ({md_busy, md_done} !== 2'b00) begin failures++; $display("FAIL rmid_md: got %b expected %b", {md_busy, md_done}, 2'b00); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rmid_stall: got %0d expected 0", stall_cnt); end
      exp_stall = 0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if ({md_busy, md_done, lden} !== 7'b0011111) begin failures++; $display("FAIL rmid_after c%0d: got %b expected %b", k, {md_busy, md_done, lden}, 7'b0011111); end
      end
      checks++; if (s_stall_cnt !== 4'd0) begin failures++; $display("FAIL rmid_sat0: got %0d expected 0", s_stall_cnt); end
   endtask

   task automatic test_saturation();
      for (int i = 1; i <= 20; i++) begin
         ext_stall = 1;
         tick();
         if (i == 14) begin
            checks++; if (s_stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_14: got %0d expected 14", s_stall_cnt); end
         end
      end
      clear_inputs();
      checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_15: got %0d expected 15", s_stall_cnt); end
      checks++; if (stall_cnt !== 16'd20) begin failures++; $display("FAIL sat_wide: got %0d expected 20", stall_cnt); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_muldiv();
      test_stall_overlap();
      test_exception();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu6_pipe_ctrl.md
CPU6_PIPE_CTRL -- requirements
Module: cpu6_pipe_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 8, meaning multi-cycle mul/div latency in cycles (legal 2..15).
REQ-002 SHALL have parameter SCW, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- ext_stall  in  1  memory wait; freeze whole pipe
- exc  in  1  exception from MEM; flush younger stages
- br_taken  in  1  branch resolved taken in EX
- ex_load  in  1  EX holds a load
- ex_rd  in  5  EX destination register
- id_rs1, id_rs2  in  5 each  ID source registers
- id_rs1_used, id_rs2_used  in  1 each  source valid
- md_start  in  1  EX issues a mul/div
- if_lden, id_lden, ex_lden, mem_lden, wb_lden  out  1 each  pipeline register load enables
- id_flush, ex_flush, mem_flush  out  1 each  load a bubble into that stage register
- md_busy  out  1  mul/div sequence in progress
- md_done  out  1  one-cycle pulse when the mul/div result is ready
- stall_cnt  out  SCW  saturating count of cycles with if_lden=0

Function
REQ-005 SHALL implement states RUN, MDWAIT and MDHOLD in a registered FSM, together with a 4-bit down-counter md_cnt.
REQ-006 SHALL detect load-use as: ex_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-007 SHALL apply output priority in this order, highest first: exc, ext_stall, MDWAIT/MDHOLD, md_start, br_taken, load-use, normal.
REQ-008 SHALL, on exc in any state: set all lden=1, id_flush=ex_flush=mem_flush=1, move to RUN next cycle, clear md_cnt, and suppress md_done.
REQ-009 SHALL, on ext_stall (without exc): set all lden=0 and all flushes=0; FSM state is held except md_cnt, which keeps counting in MDWAIT.
REQ-010 SHALL, in RUN with md_start: set if/id/ex_lden=0, mem_lden=wb_lden=1, mem_flush=1, load md_cnt=MD_LAT-1 and move to MDWAIT.
REQ-011 SHALL, in MDWAIT: hold the same lden/flush pattern as REQ-010 and decrement md_cnt each cycle.
REQ-012 SHALL, in MDWAIT with md_cnt==0: move to RUN if ext_stall=0, otherwise move to MDHOLD.
REQ-013 SHALL, in MDHOLD: move to RUN when ext_stall=0.
REQ-014 SHALL assert md_done for exactly the one cycle in which the FSM leaves MDWAIT/MDHOLD for RUN, with all lden=1 and no flush in that cycle.
REQ-015 SHALL assert md_busy=1 whenever state is MDWAIT or MDHOLD.
REQ-016 SHALL ignore md_start, br_taken and load-use while in MDWAIT or MDHOLD.
REQ-017 SHALL, on br_taken in RUN: set all lden=1 and id_flush=ex_flush=1; br_taken SHALL override a simultaneous load-use.
REQ-018 SHALL, on load-use in RUN: set if_lden=id_lden=0, ex_lden=mem_lden=wb_lden=1 and ex_flush=1, giving exactly one bubble per hazard instance.
REQ-019 SHALL, in normal RUN: set all lden=1 and all flushes=0.
REQ-020 SHALL make all outputs except stall_cnt and md_busy combinational from the current state and inputs, with no added latency.
REQ-021 SHALL increment stall_cnt by 1 on each clk edge where if_lden=0 and rst_n=1, saturating at 2^SCW-1 with no wrap.
REQ-022 SHALL treat ex_rd==0 as never hazarding, since x0 is hardwired zero.

Reset
REQ-023 SHALL, while rst_n=0: force state=RUN, md_cnt=0 and stall_cnt=0, and drive all lden=0, all flushes=0, md_busy=0 and md_done=0.
REQ-024 SHALL take effect asynchronously on the falling edge of rst_n, including mid-MDWAIT, with no md_done pulse afterwards.
REQ-025 SHALL resume normal RUN behaviour on the first clk edge after rst_n rises.

Verification
REQ-026 SHALL cover load-use: ex_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> if_lden=id_lden=0, ex_flush=1 for 1 cycle, stall_cnt=1.
REQ-027 SHALL cover mul/div: md_start pulse with MD_LAT=8 -> md_busy=1 for 8 cycles, md_done pulses on the 9th cycle, stall_cnt=8.
REQ-028 SHALL cover stall overlap: ext_stall=1 spanning md_cnt reaching 0 -> FSM enters MDHOLD, all lden=0, md_done delayed to the first cycle after ext_stall falls.
REQ-029 SHALL cover branch versus hazard: br_taken=1 together with a load-use condition -> all lden=1, id_flush=ex_flush=1, stall_cnt unchanged.
REQ-030 SHALL cover exception abort: exc=1 in MDWAIT with md_cnt=3 -> all flushes=1, RUN next cycle, md_done never asserted.
REQ-031 SHALL cover reset and saturation: rst_n low mid-MDWAIT -> immediate RUN with outputs 0; with SCW=4 and 20 stall cycles -> stall_cnt=15.
